// File: rtl/ecg_peak_detector_pkg.sv
// Shared types and sizing helpers for the ECG R-peak detection chain.
// Holds the detector FSM state encoding and the MWI accumulator width rule.
package ecg_pkg;

    localparam int unsigned ECG_DATA_W = 16;
    localparam int unsigned ECG_RR_W   = 16;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ABOVE   = 2'd1,
        ST_REFRACT = 2'd2
    } ecg_state_e;

    // A WIN_LEN-deep sum of DATA_W values needs log2(WIN_LEN) extra bits.
    function automatic int unsigned mwi_sum_width(input int unsigned data_w,
                                                  input int unsigned win_len);
        return data_w + $clog2(win_len);
    endfunction

endpackage

// File: rtl/ecg_peak_detector_moving_window_sum.sv
// Moving-window integrator: WIN_LEN-deep shift window, running sum, and
// power-of-two divide. One cycle from valid_in to valid_out; output held between updates.
module moving_window_sum
    import ecg_pkg::*;
#(
    parameter int unsigned DATA_W  = ECG_DATA_W,
    parameter int unsigned WIN_LEN = 8
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic [DATA_W-1:0] abs_in,
    input  logic              valid_in,
    output logic [DATA_W-1:0] avg_out,
    output logic              valid_out
);

    localparam int unsigned SHIFT = $clog2(WIN_LEN);
    localparam int unsigned SUM_W = mwi_sum_width(DATA_W, WIN_LEN);

    logic [DATA_W-1:0] win_q [WIN_LEN];
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [DATA_W-1:0] avg_q, avg_d;
    logic              valid_q;

    always_comb begin
        sum_d = sum_q;
        avg_d = avg_q;
        if (valid_in) begin
            // sum_q always contains the oldest entry, so the subtraction never wraps.
            sum_d = sum_q + SUM_W'(abs_in) - SUM_W'(win_q[WIN_LEN-1]);
            avg_d = DATA_W'(sum_d >> SHIFT);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int unsigned i = 0; i < WIN_LEN; i++) begin
                win_q[i] <= '0;
            end
            sum_q   <= '0;
            avg_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            avg_q   <= avg_d;
            valid_q <= valid_in;
            if (valid_in) begin
                win_q[0] <= abs_in;
                for (int unsigned i = 1; i < WIN_LEN; i++) begin
                    win_q[i] <= win_q[i-1];
                end
            end
        end
    end

    assign avg_out   = avg_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/ecg_peak_detector.sv
// ECG R-peak detector: saturating rectifier, MWI smoothing, threshold/refractory FSM, RR counter.
// Define ECG_ADAPTIVE_THRESH_EN to let the threshold track detected peak amplitudes.
module ecg_peak_detector
    import ecg_pkg::*;
#(
    parameter int unsigned DATA_W  = ECG_DATA_W,
    parameter int unsigned WIN_LEN = 8,
    parameter int unsigned THRESH  = 2000,
    parameter int unsigned REFRACT = 40,
    parameter int unsigned RR_W    = ECG_RR_W
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] x,
    output logic [DATA_W-1:0]        mwi_out,
    output logic                     mwi_valid,
    output logic                     peak,
    output logic [DATA_W-1:0]        peak_amp,
    output logic [RR_W-1:0]          rr_interval,
    output logic                     rr_valid
);

    localparam int unsigned RCNT_W = $clog2(REFRACT + 2);

    logic [DATA_W-1:0] abs_q, abs_d;
    logic              abs_vld_q;

    ecg_state_e        state_q, state_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [DATA_W-1:0] thr_q, thr_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic [RR_W-1:0]   rrcnt_q, rrcnt_d;
    logic [RR_W-1:0]   rr_sat;
    logic              seen_q, seen_d;
    logic              peak_q, peak_d;
    logic [DATA_W-1:0] amp_q, amp_d;
    logic [RR_W-1:0]   rr_q, rr_d;
    logic              rrv_q, rrv_d;

    always_comb begin
        abs_d = abs_q;
        if (in_valid) begin
            if (x == {1'b1, {(DATA_W-1){1'b0}}}) begin
                abs_d = {1'b0, {(DATA_W-1){1'b1}}};
            end else if (x[DATA_W-1]) begin
                abs_d = DATA_W'(-x);
            end else begin
                abs_d = DATA_W'(x);
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            abs_q     <= '0;
            abs_vld_q <= 1'b0;
        end else begin
            abs_q     <= abs_d;
            abs_vld_q <= in_valid;
        end
    end

    moving_window_sum #(
        .DATA_W  (DATA_W),
        .WIN_LEN (WIN_LEN)
    ) u_mws (
        .clk       (clk),
        .rstN      (rstN),
        .abs_in    (abs_q),
        .valid_in  (abs_vld_q),
        .avg_out   (mwi_out),
        .valid_out (mwi_valid)
    );

    assign rr_sat = (rrcnt_q == '1) ? rrcnt_q : rrcnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        thr_d   = thr_q;
        rcnt_d  = rcnt_q;
        rrcnt_d = rrcnt_q;
        seen_d  = seen_q;
        peak_d  = 1'b0;
        amp_d   = amp_q;
        rr_d    = rr_q;
        rrv_d   = 1'b0;
        if (mwi_valid) begin
            rrcnt_d = rr_sat;
            unique case (state_q)
                ST_SEARCH: begin
                    if (mwi_out >= thr_q) begin
                        state_d = ST_ABOVE;
                        max_d   = mwi_out;
                    end
                end
                ST_ABOVE: begin
                    if (mwi_out < thr_q) begin
                        // The falling-edge sample itself is counted in the interval just closed.
                        peak_d  = 1'b1;
                        amp_d   = max_q;
                        rr_d    = rr_sat;
                        rrv_d   = seen_q;
                        rrcnt_d = '0;
                        seen_d  = 1'b1;
`ifdef ECG_ADAPTIVE_THRESH_EN
                        begin
                            logic [DATA_W-1:0] thr_cand;
                            thr_cand = (thr_q >> 1) + (max_q >> 2);
                            thr_d    = (thr_cand > DATA_W'(THRESH)) ? thr_cand : DATA_W'(THRESH);
                        end
`endif
                        if (REFRACT == 0) begin
                            state_d = ST_SEARCH;
                        end else begin
                            state_d = ST_REFRACT;
                            rcnt_d  = RCNT_W'(REFRACT);
                        end
                    end else if (mwi_out > max_q) begin
                        max_d = mwi_out;
                    end
                end
                ST_REFRACT: begin
                    if (rcnt_q <= RCNT_W'(1)) begin
                        state_d = ST_SEARCH;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q - 1'b1;
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= ST_SEARCH;
            max_q   <= '0;
            thr_q   <= DATA_W'(THRESH);
            rcnt_q  <= '0;
            rrcnt_q <= '0;
            seen_q  <= 1'b0;
            peak_q  <= 1'b0;
            amp_q   <= '0;
            rr_q    <= '0;
            rrv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            thr_q   <= thr_d;
            rcnt_q  <= rcnt_d;
            rrcnt_q <= rrcnt_d;
            seen_q  <= seen_d;
            peak_q  <= peak_d;
            amp_q   <= amp_d;
            rr_q    <= rr_d;
            rrv_q   <= rrv_d;
        end
    end

    assign peak        = peak_q;
    assign peak_amp    = amp_q;
    assign rr_interval = rr_q;
    assign rr_valid    = rrv_q;

endmodule

// File: tb/tb_ecg_peak_detector.sv
// Randomised and directed bench for ecg_peak_detector against a sample-level
// behavioural model that schedules expected outputs by absolute cycle number.
module tb_ecg_peak_detector;

    localparam int DATA_W  = 16;
    localparam int WIN_LEN = 8;
    localparam int THRESH  = 2000;
    localparam int REFRACT = 40;
    localparam int RR_W    = 16;
    localparam int MAXC    = 20000;

    logic                     clk = 1'b0;
    logic                     rstN = 1'b0;
    logic                     in_valid = 1'b0;
    logic signed [DATA_W-1:0] x = '0;
    logic [DATA_W-1:0]        mwi_out;
    logic                     mwi_valid;
    logic                     peak;
    logic [DATA_W-1:0]        peak_amp;
    logic [RR_W-1:0]          rr_interval;
    logic                     rr_valid;

    ecg_peak_detector #(
        .DATA_W  (DATA_W),
        .WIN_LEN (WIN_LEN),
        .THRESH  (THRESH),
        .REFRACT (REFRACT),
        .RR_W    (RR_W)
    ) dut (
        .clk         (clk),
        .rstN        (rstN),
        .in_valid    (in_valid),
        .x           (x),
        .mwi_out     (mwi_out),
        .mwi_valid   (mwi_valid),
        .peak        (peak),
        .peak_amp    (peak_amp),
        .rr_interval (rr_interval),
        .rr_valid    (rr_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected output events keyed by the cycle they become visible.
    bit e_mv  [MAXC];
    int e_mwi [MAXC];
    bit e_pk  [MAXC];
    int e_amp [MAXC];
    int e_rr  [MAXC];
    bit e_rrv [MAXC];
    int h_mwi = 0, h_amp = 0, h_rr = 0;

    int win[$];
    int m_thr, m_max, m_refr, m_since;
    bit m_in_peak, m_seen;

    task automatic model_reset();
        win = {};
        for (int i = 0; i < WIN_LEN; i++) win.push_back(0);
        m_thr = THRESH; m_max = 0; m_refr = 0; m_since = 0;
        m_in_peak = 0; m_seen = 0;
    endtask

    task automatic model_sample(input int v, input int k);
        int ab, s, m;
        ab = (v < 0) ? -v : v;
        if (ab > 32767) ab = 32767;
        win.push_front(ab);
        void'(win.pop_back());
        s = 0;
        foreach (win[i]) s += win[i];
        m = s / WIN_LEN;
        e_mv[k+2] = 1; e_mwi[k+2] = m;
        if (m_since < 65535) m_since++;
        if (m_refr > 0) begin
            m_refr--;
        end else if (!m_in_peak) begin
            if (m >= m_thr) begin m_in_peak = 1; m_max = m; end
        end else if (m >= m_thr) begin
            if (m > m_max) m_max = m;
        end else begin
            e_pk[k+3] = 1; e_amp[k+3] = m_max; e_rr[k+3] = m_since; e_rrv[k+3] = m_seen;
            m_since = 0; m_seen = 1; m_in_peak = 0; m_refr = REFRACT;
`ifdef ECG_ADAPTIVE_THRESH_EN
            m_thr = (m_thr / 2 + m_max / 4 > THRESH) ? m_thr / 2 + m_max / 4 : THRESH;
`endif
        end
    endtask

    bit chk_en = 0;
    int n_peaks = 0;
    int last_amp = 0, last_rr = 0;
    bit last_rrv = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            if (e_mv[cyc]) h_mwi = e_mwi[cyc];
            if (e_pk[cyc]) begin h_amp = e_amp[cyc]; h_rr = e_rr[cyc]; end
            check("mwi_valid", 32'(mwi_valid), 32'(e_mv[cyc]));
            check("mwi_out", 32'(mwi_out), h_mwi);
            check("peak", 32'(peak), 32'(e_pk[cyc]));
            check("peak_amp", 32'(peak_amp), h_amp);
            check("rr_interval", 32'(rr_interval), h_rr);
            check("rr_valid", 32'(rr_valid), 32'(e_rrv[cyc]));
            if (peak === 1'b1) begin
                n_peaks++;
                last_amp = int'(peak_amp);
                last_rr  = int'(rr_interval);
                last_rrv = rr_valid;
            end
        end
    end

    task automatic send(input int v, input bit vld);
        @(negedge clk);
        if (cyc + 4 >= MAXC) begin
            $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC - 4);
            $fatal(1);
        end
        x = DATA_W'(v);
        in_valid = vld;
        if (vld) model_sample(v, cyc);
    endtask

    task automatic run(input int v, input int n);
        for (int i = 0; i < n; i++) send(v, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(0, 1'b0);
    endtask

    int p0;

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        check("reset_mwi_out", 32'(mwi_out), 0);
        check("reset_peak_amp", 32'(peak_amp), 0);
        check("reset_rr_interval", 32'(rr_interval), 0);
        chk_en = 1;

        // Zero input
        p0 = n_peaks;
        run(0, 200); idle(4);
        check("zero_no_peak", n_peaks - p0, 0);

        // Positive pulse with first MWI value pinned
        p0 = n_peaks;
        send(3000, 1'b1); send(0, 1'b0);
        @(negedge clk);
        check("ramp_first_mwi", 32'(mwi_out), 375);
        run(3000, 19); run(0, 80); idle(4);
        check("pos_peak_count", n_peaks - p0, 1);
        check("pos_peak_amp", last_amp, 3000);
        check("pos_first_rr_valid", 32'(last_rrv), 0);

        // Negative pulse
        p0 = n_peaks;
        run(-3000, 20); run(0, 80); idle(4);
        check("neg_peak_count", n_peaks - p0, 1);
        check("neg_peak_amp", last_amp, 3000);

        // Most negative sample saturates to 32767 -> average 4095
        send(-32768, 1'b1); send(0, 1'b0);
        @(negedge clk);
        check("extreme_mwi", 32'(mwi_out), 4095);
        run(0, 80);

        // Two peaks 100 samples apart
        p0 = n_peaks;
        run(3000, 20); run(0, 80); run(3000, 20); run(0, 80); idle(4);
        check("two_peak_count", n_peaks - p0, 2);
        check("two_peak_rr", last_rr, 100);
        check("two_peak_rr_valid", 32'(last_rrv), 1);

        // Second pulse inside the refractory window
        p0 = n_peaks;
        run(3000, 20); run(0, 20); run(3000, 20); run(0, 80); idle(4);
        check("refract_count", n_peaks - p0, 1);

        // Same pattern with in_valid at 50%
        p0 = n_peaks;
        for (int i = 0; i < 140; i++) begin
            send((i < 20 || (i >= 40 && i < 60)) ? 3000 : 0, 1'b1);
            send(12345, 1'b0);
        end
        idle(4);
        check("toggle_count", n_peaks - p0, 1);

        // Reset while above threshold
        p0 = n_peaks;
        run(3000, 10);
        @(negedge clk);
        #2;
        rstN = 1'b0;
        in_valid = 1'b0;
        #1;
        check("arst_mwi_out", 32'(mwi_out), 0);
        check("arst_mwi_valid", 32'(mwi_valid), 0);
        check("arst_peak", 32'(peak), 0);
        check("arst_peak_amp", 32'(peak_amp), 0);
        check("arst_rr_interval", 32'(rr_interval), 0);
        check("arst_rr_valid", 32'(rr_valid), 0);
        for (int i = cyc + 1; i < cyc + 6; i++) begin
            e_mv[i] = 0; e_pk[i] = 0; e_rrv[i] = 0;
        end
        h_mwi = 0; h_amp = 0; h_rr = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        check("arst_no_peak", n_peaks - p0, 0);
        run(3000, 20); run(0, 80); idle(4);
        check("post_rst_count", n_peaks - p0, 1);
        check("post_rst_rr_valid", 32'(last_rrv), 0);
        check("post_rst_amp", last_amp, 3000);

        // Randomised pulses, gaps, noise on idle cycles and occasional full-scale negatives
        p0 = cyc;
        while (cyc < p0 + 4000) begin
            int amp, len, gap;
            amp = int'($urandom_range(6000));
            if ($urandom_range(1) == 1) amp = -amp;
            len = int'($urandom_range(30, 1));
            gap = int'($urandom_range(80));
            for (int i = 0; i < len + gap; i++) begin
                int v;
                v = (i < len) ? (($urandom_range(19) == 0) ? -32768 : amp) : 0;
                if ($urandom_range(3) == 0) send(int'($urandom), 1'b0);
                else send(v, 1'b1);
            end
        end
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ecg_peak_detector.md
Name: ecg_peak_detector

Overview:
- Downstream consumer of the 3-tap FIR output (signed 16-bit `y`) in the ECG processing chain.
- Rectifies the filtered signal and smooths it with a moving-window integrator (MWI).
- Detects R-peaks using a threshold/refractory state machine.
- Reports a peak strobe, the peak amplitude and the RR interval, measured in accepted samples.

Parameters:
- DATA_W, 16, sample width; signed input, unsigned MWI.
- WIN_LEN, 8, MWI window length in samples; power of two, range 2..64.
- THRESH, 2000, detection threshold on `mwi_out`. In adaptive mode it is the initial threshold and the floor.
- REFRACT, 40, accepted samples ignored after a peak.
- RR_W, 16, RR interval counter width.

Ports:
- clk  in  1  system clock
- rstN  in  1  asynchronous active-low reset
- in_valid  in  1  `x` is a new sample this cycle
- x  in  DATA_W  signed filtered ECG sample (FIR `y`)
- mwi_out  out  DATA_W  unsigned MWI average
- mwi_valid  out  1  `mwi_out` updated this cycle
- peak  out  1  one-cycle R-peak strobe
- peak_amp  out  DATA_W  max `mwi_out` of the detected peak; valid with `peak`, held until the next peak
- rr_interval  out  RR_W  samples since the previous peak; held until the next update
- rr_valid  out  1  one-cycle strobe with `peak`, but not on the first peak after reset

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (`clk`, `rstN`).
  - All outputs, window contents, sums, counters and max registers go to 0.
  - FSM goes to SEARCH; the first-peak flag is cleared; the threshold register loads THRESH.
- Stage 1, cycle after `in_valid`: `abs = |x|`, saturating, so -32768 gives 32767.
- Stage 2, next cycle:
  - Shift `abs` into a WIN_LEN-deep window.
  - `sum += new - oldest`; sum width is DATA_W + log2(WIN_LEN), so it never overflows.
  - `mwi_out = sum >> log2(WIN_LEN)` and `mwi_valid` pulses.
  - Total latency from `in_valid` to `mwi_valid` is 2 cycles.
- Nothing advances while `in_valid` is low: no window shift and no counter increment.
- FSM advances only on `mwi_valid`:
  - SEARCH: if `mwi_out >= thr`, go to ABOVE and set `max = mwi_out`.
  - ABOVE: update `max = max(max, mwi_out)`. If `mwi_out < thr`, assert `peak` in the next cycle, latch `peak_amp = max` and go to REFRACT with `rcnt = REFRACT`.
  - REFRACT: decrement `rcnt` per `mwi_valid`. At 0, return to SEARCH, even if `mwi_out` is still >= thr.
- RR counter:
  - Increments per `mwi_valid`, saturating at 2^RR_W - 1.
  - On a peak, `rr_interval` takes the counter value and the counter restarts from 0 on that same strobe.
  - `rr_valid` is suppressed on the first peak after reset.
- A `peak` strobe and a new `in_valid` in the same cycle are both handled; no sample is lost.
- Reset asserted mid-ABOVE aborts the peak; no strobe is emitted.

Optional Feature:
- ECG_ADAPTIVE_THRESH_EN defined:
  - At each peak, `thr <= max(THRESH, (thr >> 1) + (peak_amp >> 2))`.
  - The update takes effect from the next `mwi_valid`.
- Undefined: `thr` stays constant at THRESH.

Decomposition:
- Package `ecg_pkg`:
  - FSM state enum (SEARCH, ABOVE, REFRACT).
  - DATA_W, RR_W defaults.
  - Function computing the sum width from WIN_LEN.
- Sub-module `moving_window_sum`:
  - Contains the window shift register, running sum and shift divide.
  - Interface: `abs_in`/`valid_in` in, `avg_out`/`valid_out` out.

Test Plan:
- Zero input: `x = 0` for 200 valid samples → `mwi_out = 0`, no `peak`, no `rr_valid`.
- Positive pulse: WIN_LEN=8, `x = 3000` for 20 samples then 0 → `mwi_out` ramps 375, 750, …, 3000. Enters ABOVE on the 6th sample (2250). Exactly one `peak`, with `peak_amp = 3000` and `rr_valid` low.
- Negative and extreme input: same pulse with `x = -3000` → identical response. A single `x = -32768` → stage-1 abs = 32767.
- Two peaks 100 samples apart: two identical pulses starting 100 samples apart → second peak has `rr_interval = 100` and `rr_valid = 1`.
- Refractory suppression: second pulse starts 20 samples after the first falls below threshold, with REFRACT=40 → no second `peak`. With `in_valid` toggling 50%, timing scales and counts are unchanged.
- Reset mid-operation: assert `rstN` low while in ABOVE → all outputs 0 asynchronously. After release, a new pulse yields `peak` with `rr_valid` low. With ECG_ADAPTIVE_THRESH_EN, after `peak_amp = 3000`, `thr = max(2000, 1000 + 750) = 2000`.
